// File: rtl/pf_lanectrl_dly_seq.sv
// Multi-lane LANECTRL delay-line sequencer: runs one LOAD/MOVE tap command at a
// time inside a per-lane HS_IO clock-pause window and tracks every lane's tap offset.
module pf_lanectrl_dly_seq #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned LANE_W     = 2,
    parameter int unsigned TAP_W      = 8,
    parameter int unsigned PAUSE_PRE  = 2,
    parameter int unsigned PAUSE_POST = 2,
    parameter int unsigned MOVE_GAP   = 3
) (
    input  logic                 FAB_CLK,
    input  logic                 RESET_N,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [LANE_W-1:0]    REQ_LANE,
    input  logic                 REQ_SEL,
    input  logic                 REQ_LOAD,
    input  logic                 REQ_DIR,
    input  logic [TAP_W-1:0]     REQ_COUNT,
    input  logic [NUM_LANES-1:0] RX_OOR,
    input  logic [NUM_LANES-1:0] TX_OOR,
    output logic [NUM_LANES-1:0] DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    output logic                 DONE,
    output logic                 ERR,
    output logic [TAP_W-1:0]     STEPS_DONE,
    output logic [TAP_W-1:0]     TAP_POS
);

    localparam int unsigned      CNT_W     = 4;
    localparam int unsigned      NPOS      = 1 << LANE_W;
    localparam logic [TAP_W-1:0] POS_MAX   = {1'b0, {(TAP_W-1){1'b1}}};
    localparam logic [TAP_W-1:0] POS_MIN   = {1'b1, {(TAP_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PAUSE_PRE);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(PAUSE_POST);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MOVE_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_GAP,
        S_POST,
        S_FIN
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [LANE_W-1:0]    r_lane;
    logic                 r_sel;
    logic                 r_load;
    logic                 r_dir;
    logic [TAP_W-1:0]     r_count;
    logic [TAP_W-1:0]     r_steps;
    logic                 r_err;
    logic                 r_sat;
    logic [TAP_W-1:0]     r_pos [2][NPOS];

    logic [NUM_LANES-1:0] r_dl_sel;
    logic [NUM_LANES-1:0] r_dl_load;
    logic [NUM_LANES-1:0] r_dl_move;
    logic [NUM_LANES-1:0] r_dl_dir;
    logic [NUM_LANES-1:0] r_pause;
    logic                 r_done;
    logic                 r_err_o;
    logic [TAP_W-1:0]     r_steps_o;
    logic [TAP_W-1:0]     r_tap_pos;

    logic [NUM_LANES-1:0] w_req_oh;
    logic [NUM_LANES-1:0] w_lane_oh;
    logic                 w_oor;
    logic [TAP_W-1:0]     w_pos_cur;
    logic [TAP_W-1:0]     w_pos_nxt;
    logic                 w_sat_hit;

    assign REQ_READY = (r_state == S_IDLE) & RESET_N;

    // Lane decode for the incoming request and for the latched command.
    always_comb begin
        w_req_oh  = '0;
        w_lane_oh = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            w_req_oh[i]  = (REQ_LANE == LANE_W'(i));
            w_lane_oh[i] = (r_lane == LANE_W'(i));
        end
    end

    assign w_oor     = |((r_sel ? TX_OOR : RX_OOR) & w_lane_oh);
    assign w_pos_cur = r_pos[r_sel][r_lane];

    // Signed +/-1 step that sticks at the range limits and flags the overflow.
    always_comb begin
        w_pos_nxt = w_pos_cur;
        w_sat_hit = 1'b0;
        if (r_dir) begin
            if (w_pos_cur == POS_MAX) w_sat_hit = 1'b1;
            else                      w_pos_nxt = w_pos_cur + TAP_W'(1);
        end else begin
            if (w_pos_cur == POS_MIN) w_sat_hit = 1'b1;
            else                      w_pos_nxt = w_pos_cur - TAP_W'(1);
        end
    end

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lane    <= '0;
            r_sel     <= 1'b0;
            r_load    <= 1'b0;
            r_dir     <= 1'b0;
            r_count   <= '0;
            r_steps   <= '0;
            r_err     <= 1'b0;
            r_sat     <= 1'b0;
            r_dl_sel  <= '0;
            r_dl_load <= '0;
            r_dl_move <= '0;
            r_dl_dir  <= '0;
            r_pause   <= '0;
            r_done    <= 1'b0;
            r_err_o   <= 1'b0;
            r_steps_o <= '0;
            r_tap_pos <= '0;
            for (int s = 0; s < 2; s++) begin
                for (int l = 0; l < int'(NPOS); l++) begin
                    r_pos[s][l] <= '0;
                end
            end
        end else begin
            r_dl_load <= '0;
            r_dl_move <= '0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        r_lane   <= REQ_LANE;
                        r_sel    <= REQ_SEL;
                        r_load   <= REQ_LOAD;
                        r_dir    <= REQ_DIR & ~REQ_LOAD;
                        r_count  <= REQ_COUNT;
                        r_steps  <= '0;
                        r_err    <= 1'b0;
                        r_sat    <= 1'b0;
                        r_cnt    <= CNT_W'(1);
                        r_pause  <= w_req_oh;
                        r_dl_sel <= REQ_SEL ? w_req_oh : '0;
                        r_dl_dir <= (REQ_DIR & ~REQ_LOAD) ? w_req_oh : '0;
                        r_state  <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_cnt <= CNT_W'(1);
                        if (r_load || (r_count != '0)) begin
                            r_dl_load <= r_load ? w_lane_oh : '0;
                            r_dl_move <= r_load ? '0 : w_lane_oh;
                            r_state   <= S_ACT;
                        end else begin
                            r_state <= S_POST;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    r_steps <= r_steps + TAP_W'(1);
                    r_cnt   <= CNT_W'(1);
                    if (r_load) begin
                        r_pos[r_sel][r_lane] <= '0;
                        r_state              <= S_POST;
                    end else begin
                        r_pos[r_sel][r_lane] <= w_pos_nxt;
                        r_sat                <= r_sat | w_sat_hit;
                        r_state              <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= CNT_W'(1);
                        if (w_oor || r_sat) begin
                            r_err   <= 1'b1;
                            r_state <= S_POST;
                        end else if (r_steps == r_count) begin
                            r_state <= S_POST;
                        end else begin
                            r_dl_move <= w_lane_oh;
                            r_state   <= S_ACT;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_POST: begin
                    if (r_cnt == POST_LAST) begin
                        r_pause   <= '0;
                        r_dl_sel  <= '0;
                        r_dl_dir  <= '0;
                        r_done    <= 1'b1;
                        r_err_o   <= r_err;
                        r_steps_o <= r_steps;
                        r_tap_pos <= w_pos_cur;
                        r_state   <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign DELAY_LINE_SEL       = r_dl_sel;
    assign DELAY_LINE_LOAD      = r_dl_load;
    assign DELAY_LINE_MOVE      = r_dl_move;
    assign DELAY_LINE_DIRECTION = r_dl_dir;
    assign HS_IO_CLK_PAUSE      = r_pause;
    assign DONE                 = r_done;
    assign ERR                  = r_err_o;
    assign STEPS_DONE           = r_steps_o;
    assign TAP_POS              = r_tap_pos;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// Bench for pf_lanectrl_dly_seq: directed vector table, back-to-back and reset
// corner sequences, a TAP_W=4 saturation instance, and random commands vs. a tap model.
module tb_pf_lanectrl_dly_seq;

    localparam int NL   = 4;
    localparam int LW   = 2;
    localparam int TW   = 8;
    localparam int PRE  = 2;
    localparam int POST = 2;
    localparam int GAP  = 3;
    localparam int PMAX = (1 << (TW - 1)) - 1;
    localparam int PMIN = -(1 << (TW - 1));

    typedef struct {
        int lane;
        int sel;
        int load;
        int dir;
        int count;
        int oor_k;
        int e_err;
        int e_steps;
        int e_pos;
        int e_lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, ready, sel, load, dir;
    logic [LW-1:0] lane;
    logic [TW-1:0] count;
    logic [NL-1:0] rx_oor, tx_oor;
    logic [NL-1:0] dl_sel, dl_load, dl_move, dl_dir, pause;
    logic          done, err;
    logic [TW-1:0] steps_done, tap_pos;

    logic          t4_valid, t4_ready, t4_sel, t4_load, t4_dir;
    logic [LW-1:0] t4_lane;
    logic [3:0]    t4_count;
    logic [NL-1:0] t4_rx_oor, t4_tx_oor;
    logic [NL-1:0] t4_dl_sel, t4_dl_load, t4_dl_move, t4_dl_dir, t4_pause;
    logic          t4_done, t4_err;
    logic [3:0]    t4_steps, t4_pos;

    int n_checks = 0;
    int n_fail   = 0;
    int mpos [2][NL];
    vec_t vecs [6];

    always #5 clk = ~clk;

    pf_lanectrl_dly_seq dut (
        .FAB_CLK(clk), .RESET_N(rst_n), .REQ_VALID(valid), .REQ_READY(ready),
        .REQ_LANE(lane), .REQ_SEL(sel), .REQ_LOAD(load), .REQ_DIR(dir),
        .REQ_COUNT(count), .RX_OOR(rx_oor), .TX_OOR(tx_oor),
        .DELAY_LINE_SEL(dl_sel), .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move),
        .DELAY_LINE_DIRECTION(dl_dir), .HS_IO_CLK_PAUSE(pause), .DONE(done),
        .ERR(err), .STEPS_DONE(steps_done), .TAP_POS(tap_pos)
    );

    pf_lanectrl_dly_seq #(.TAP_W(4)) dut4 (
        .FAB_CLK(clk), .RESET_N(rst_n), .REQ_VALID(t4_valid), .REQ_READY(t4_ready),
        .REQ_LANE(t4_lane), .REQ_SEL(t4_sel), .REQ_LOAD(t4_load), .REQ_DIR(t4_dir),
        .REQ_COUNT(t4_count), .RX_OOR(t4_rx_oor), .TX_OOR(t4_tx_oor),
        .DELAY_LINE_SEL(t4_dl_sel), .DELAY_LINE_LOAD(t4_dl_load), .DELAY_LINE_MOVE(t4_dl_move),
        .DELAY_LINE_DIRECTION(t4_dl_dir), .HS_IO_CLK_PAUSE(t4_pause), .DONE(t4_done),
        .ERR(t4_err), .STEPS_DONE(t4_steps), .TAP_POS(t4_pos)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tap model: walk the command step by step over signed integers.
    task automatic model_cmd(inout vec_t v);
        int p, np;
        p = mpos[v.sel][v.lane];
        v.e_err = 0;
        if (v.load != 0) begin
            p         = 0;
            v.e_steps = -1;
            v.e_lat   = PRE + 1 + POST + 1;
        end else begin
            v.e_steps = 0;
            for (int i = 1; i <= v.count; i++) begin
                v.e_steps = i;
                np = p + ((v.dir != 0) ? 1 : -1);
                if (np > PMAX || np < PMIN) v.e_err = 1;
                else                        p = np;
                if (v.oor_k == i) v.e_err = 1;
                if (v.e_err != 0) break;
            end
            v.e_lat = PRE + v.e_steps * (1 + GAP) + POST + 1;
        end
        v.e_pos = p;
        mpos[v.sel][v.lane] = p;
    endtask

    task automatic run_cmd(input vec_t v, input string nm);
        logic [NL-1:0] oh;
        int off, n_ld, n_mv, bad_t, bad_oth, bad_sd, pause_n, done_off, tmo;
        int err_a, steps_a, pos_a, pause_done, inj, edir;
        oh = NL'(1) << v.lane;
        edir = (v.load != 0) ? 0 : v.dir;
        tmo = 0;
        while (!ready && tmo < 200) begin
            tick();
            tmo++;
        end
        chk({nm, "/ready"}, int'(ready), 1);
        lane = LW'(v.lane); sel = 1'(v.sel); load = 1'(v.load);
        dir = 1'(v.dir); count = TW'(v.count); valid = 1'b1;
        tick();
        valid = 1'b0;
        lane = LW'($urandom); sel = 1'($urandom); load = 1'($urandom);
        dir = 1'($urandom); count = TW'($urandom);
        n_ld = 0; n_mv = 0; bad_t = 0; bad_oth = 0; bad_sd = 0; pause_n = 0;
        done_off = -1; err_a = -1; steps_a = -1; pos_a = 0; pause_done = -1; inj = 0;
        for (off = 1; off <= 2000; off++) begin
            if ((dl_move & oh) != 0) begin
                if (off != PRE + 1 + n_mv * (1 + GAP)) bad_t++;
                n_mv++;
                if (v.oor_k != 0 && n_mv == v.oor_k) inj = 1;
            end
            if ((dl_load & oh) != 0) begin
                if (off != PRE + 1) bad_t++;
                n_ld++;
            end
            if (((dl_sel | dl_load | dl_move | dl_dir | pause) & ~oh) != 0) bad_oth++;
            if ((pause & oh) != 0) begin
                pause_n++;
                if (int'(dl_sel[v.lane]) != v.sel || int'(dl_dir[v.lane]) != edir) bad_sd++;
            end else if (((dl_sel | dl_dir) & oh) != 0) begin
                bad_sd++;
            end
            if (done) begin
                done_off = off; err_a = int'(err); steps_a = int'(steps_done);
                pos_a = int'($signed(tap_pos)); pause_done = int'(pause[v.lane]);
                break;
            end
            rx_oor = NL'($urandom);
            tx_oor = NL'($urandom);
            if (v.sel != 0) tx_oor[v.lane] = 1'(inj);
            else            rx_oor[v.lane] = 1'(inj);
            tick();
        end
        rx_oor = '0;
        tx_oor = '0;
        chk({nm, "/done_lat"}, done_off, v.e_lat);
        chk({nm, "/err"}, err_a, v.e_err);
        if (v.load == 0) chk({nm, "/steps"}, steps_a, v.e_steps);
        chk({nm, "/tap_pos"}, pos_a, v.e_pos);
        chk({nm, "/load_pulses"}, n_ld, (v.load != 0) ? 1 : 0);
        chk({nm, "/move_pulses"}, n_mv, (v.load != 0) ? 0 : v.e_steps);
        chk({nm, "/pulse_timing"}, bad_t, 0);
        chk({nm, "/other_lanes"}, bad_oth, 0);
        chk({nm, "/sel_dir"}, bad_sd, 0);
        chk({nm, "/pause_cycles"}, pause_n, v.e_lat - 1);
        chk({nm, "/pause_at_done"}, pause_done, 0);
        tick();
        chk({nm, "/ready_after"}, int'(ready), 1);
        chk({nm, "/done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int off, n, d_off, acc, nd, cyc;
        int dts [3];
        vec_t v;

        vecs[0] = '{lane:2, sel:0, load:1, dir:0, count:0,  oor_k:0, e_err:0, e_steps:-1, e_pos:0,  e_lat:6};
        vecs[1] = '{lane:1, sel:1, load:0, dir:1, count:3,  oor_k:0, e_err:0, e_steps:3,  e_pos:3,  e_lat:17};
        vecs[2] = '{lane:1, sel:1, load:0, dir:0, count:5,  oor_k:0, e_err:0, e_steps:5,  e_pos:-2, e_lat:25};
        vecs[3] = '{lane:0, sel:0, load:0, dir:1, count:10, oor_k:4, e_err:1, e_steps:4,  e_pos:4,  e_lat:21};
        vecs[4] = '{lane:3, sel:0, load:0, dir:0, count:0,  oor_k:0, e_err:0, e_steps:0,  e_pos:0,  e_lat:5};
        vecs[5] = '{lane:1, sel:1, load:1, dir:1, count:7,  oor_k:0, e_err:0, e_steps:-1, e_pos:0,  e_lat:6};

        foreach (mpos[s, l]) mpos[s][l] = 0;
        rst_n = 1'b0; valid = 1'b0; lane = '0; sel = 1'b0; load = 1'b0; dir = 1'b0;
        count = '0; rx_oor = '0; tx_oor = '0;
        t4_valid = 1'b0; t4_lane = '0; t4_sel = 1'b0; t4_load = 1'b0; t4_dir = 1'b0;
        t4_count = '0; t4_rx_oor = '0; t4_tx_oor = '0;
        repeat (3) tick();
        chk("rst/ready_low", int'(ready), 0);
        chk("rst/pause", int'(pause), 0);
        chk("rst/move_load", int'(dl_move | dl_load), 0);
        chk("rst/sel_dir", int'(dl_sel | dl_dir), 0);
        chk("rst/done_err", int'({done, err}), 0);
        chk("rst/tap_pos", int'(tap_pos), 0);
        chk("rst/steps", int'(steps_done), 0);
        rst_n = 1'b1;
        tick();
        chk("rst/ready_high", int'(ready), 1);

        // TAP_W=4 instance: +9 from 0 saturates at +7 after the 8th pulse.
        t4_lane = 2'd0; t4_sel = 1'b0; t4_load = 1'b0; t4_dir = 1'b1; t4_count = 4'd9; t4_valid = 1'b1;
        tick();
        t4_valid = 1'b0;
        n = 0; d_off = -1;
        for (off = 1; off <= 200; off++) begin
            if (t4_dl_move[0]) n++;
            if (t4_done) begin
                d_off = off;
                break;
            end
            tick();
        end
        chk("sat4/pulses", n, 8);
        chk("sat4/done_lat", d_off, PRE + 8 * (1 + GAP) + POST + 1);
        chk("sat4/err", int'(t4_err), 1);
        chk("sat4/steps", int'(t4_steps), 8);
        chk("sat4/tap_pos", int'(t4_pos), 7);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            model_cmd(v);
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // REQ_VALID held high across three zero-count moves.
        lane = 2'd3; sel = 1'b1; load = 1'b0; dir = 1'b1; count = '0; valid = 1'b1;
        acc = 0; nd = 0;
        for (cyc = 0; cyc < 200 && nd < 3; cyc++) begin
            if (done) begin
                dts[nd] = cyc;
                nd++;
                if (pause[3]) acc += 100;
                if (nd == 3) valid = 1'b0;
            end
            if (valid && ready) acc++;
            tick();
        end
        chk("b2b/accepts", acc, 3);
        chk("b2b/dones", nd, 3);
        chk("b2b/spacing1", dts[1] - dts[0], PRE + POST + 2);
        chk("b2b/spacing2", dts[2] - dts[1], PRE + POST + 2);
        repeat (4) tick();
        chk("b2b/no_extra_done", int'(done), 0);
        chk("b2b/tap_pos", int'($signed(tap_pos)), mpos[1][3]);

        for (int i = 0; i < 40; i++) begin
            v.lane = $urandom_range(0, NL - 1);
            v.sel = $urandom_range(0, 1);
            v.load = ($urandom_range(0, 7) == 0) ? 1 : 0;
            v.dir = $urandom_range(0, 1);
            v.count = $urandom_range(0, 6);
            v.oor_k = ($urandom_range(0, 3) == 0 && v.count > 0) ? $urandom_range(1, v.count) : 0;
            model_cmd(v);
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        // Reset asserted in the 2nd GAP of a count=5 move.
        lane = 2'd2; sel = 1'b1; load = 1'b0; dir = 1'b1; count = 8'd5; valid = 1'b1;
        tick();
        valid = 1'b0;
        n = 0;
        for (off = 1; off < 8; off++) begin
            if (dl_move[2]) n++;
            tick();
        end
        chk("rstmid/pulses_before", n, 2);
        rst_n = 1'b0;
        tick();
        chk("rstmid/pause", int'(pause), 0);
        chk("rstmid/move", int'(dl_move), 0);
        chk("rstmid/sel", int'(dl_sel), 0);
        chk("rstmid/tap_pos", int'(tap_pos), 0);
        chk("rstmid/ready_low", int'(ready), 0);
        rst_n = 1'b1;
        foreach (mpos[s, l]) mpos[s][l] = 0;
        tick();
        chk("rstmid/ready_high", int'(ready), 1);
        nd = 0;
        for (cyc = 0; cyc < 25; cyc++) begin
            if (done) nd++;
            tick();
        end
        chk("rstmid/no_done", nd, 0);
        v = '{lane:2, sel:1, load:0, dir:1, count:0, oor_k:0, e_err:0, e_steps:0, e_pos:0, e_lat:0};
        model_cmd(v);
        run_cmd(v, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
